// File: rtl/pc_ctrl_ras_pkg.sv
// Shared command and target-source encodings for the PC unit and its testbench.
package pc_pkg;

   localparam logic [2:0] PC_HOLD = 3'b000;
   localparam logic [2:0] PC_JMP  = 3'b001;
   localparam logic [2:0] PC_INC  = 3'b010;
   localparam logic [2:0] PC_RST  = 3'b011;
   localparam logic [2:0] PC_CALL = 3'b100;
   localparam logic [2:0] PC_RET  = 3'b101;

   localparam logic [1:0] TGT_RESULT = 2'b00;
   localparam logic [1:0] TGT_IMM    = 2'b01;
   localparam logic [1:0] TGT_RD     = 2'b10;
   localparam logic [1:0] TGT_ZERO   = 2'b11;

endpackage

// File: rtl/pc_ctrl_ras_if.sv
// Control/fetch-side bundle of the PC unit; misalign exists only when PC_ALIGN_TRAP_EN is defined.
interface pc_ctrl_ras_if #(
   parameter int PC_W  = 10,
   parameter int IMM_W = 10
);
   logic [2:0]       pc_sel;
   logic [1:0]       tgt_sel;
   logic [31:0]      result;
   logic [31:0]      rd_val;
   logic [IMM_W-1:0] imm;
   logic             stall;
   logic             fetch_ready;
   logic [PC_W-1:0]  pc;
   logic [PC_W-1:0]  pc_seq;
   logic             fetch_valid;
   logic             ras_empty;
   logic             ras_full;
   logic             ras_ovf;
   logic             ras_unf;
`ifdef PC_ALIGN_TRAP_EN
   logic             misalign;
`endif

   modport master (
      output pc_sel, tgt_sel, result, rd_val, imm, stall, fetch_ready,
      input  pc, pc_seq, fetch_valid, ras_empty, ras_full, ras_ovf, ras_unf
`ifdef PC_ALIGN_TRAP_EN
      , input misalign
`endif
   );

   modport slave (
      input  pc_sel, tgt_sel, result, rd_val, imm, stall, fetch_ready,
      output pc, pc_seq, fetch_valid, ras_empty, ras_full, ras_ovf, ras_unf
`ifdef PC_ALIGN_TRAP_EN
      , output misalign
`endif
   );
endinterface

// File: rtl/pc_ctrl_ras_ras.sv
// Return-address stack: circular buffer whose push overwrites the oldest entry when full.
module pc_ras #(
   parameter int W     = 10,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] ptr_q, ptr_d, top_idx;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];

   // ptr_q is the next free slot; once full it also indexes the oldest entry
   assign top_idx = ptr_q - PW'(1);
   assign dout    = mem_q[top_idx];
   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));

   always_comb begin
      mem_d = mem_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (push) begin
         mem_d[ptr_q] = din;
         ptr_d        = ptr_q + PW'(1);
         if (!full) cnt_d = cnt_q + CW'(1);
      end else if (pop && !empty) begin
         ptr_d = top_idx;
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: rtl/pc_ctrl_ras.sv
// Fetch-stage PC unit with return-address stack; PC_ALIGN_TRAP_EN selects trap vs. forced alignment.
module pc_ctrl_ras
   import pc_pkg::*;
#(
   parameter int PC_W      = 10,
   parameter int INC       = 2,
   parameter int IMM_W     = 10,
   parameter int RAS_DEPTH = 4,
   parameter int RESET_VEC = 0,
   parameter int TRAP_VEC  = 0
) (
   input logic           clk,
   input logic           reset,
   pc_ctrl_ras_if.slave  io
);
   localparam logic [PC_W-1:0] INC_MASK   = PC_W'(INC - 1);
   localparam logic [PC_W-1:0] ALIGN_MASK = ~INC_MASK;

   logic [PC_W-1:0] pc_q, pc_d, pc_seq, tgt, dest, ras_dout;
   logic            fetch_valid_q, ovf_q, ovf_d, unf_q, unf_d;
   logic            adv, push, pop, redirect, ras_empty, ras_full;
   logic            unused_hi;
`ifdef PC_ALIGN_TRAP_EN
   logic            misalign_q, misalign_d;
`endif

   assign unused_hi = ^{io.result[31:PC_W], io.rd_val[31:PC_W]};
   assign pc_seq    = pc_q + PC_W'(INC);
   assign adv       = fetch_valid_q & io.fetch_ready & ~io.stall;

   always_comb begin
      tgt = '0;
      case (io.tgt_sel)
         TGT_RESULT: tgt = io.result[PC_W-1:0];
         TGT_IMM:    tgt = PC_W'(io.imm);
         TGT_RD:     tgt = io.rd_val[PC_W-1:0];
         default:    tgt = '0;
      endcase
   end

   pc_ras #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (pc_seq),
      .dout  (ras_dout),
      .empty (ras_empty),
      .full  (ras_full)
   );

   // Commands are only acted on in an advance cycle; otherwise they are dropped
   always_comb begin
      pc_d     = pc_q;
      push     = 1'b0;
      pop      = 1'b0;
      redirect = 1'b0;
      dest     = tgt;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
`ifdef PC_ALIGN_TRAP_EN
      misalign_d = 1'b0;
`endif
      if (adv) begin
         case (io.pc_sel)
            PC_JMP:  redirect = 1'b1;
            PC_INC:  pc_d = pc_seq;
            PC_RST:  pc_d = PC_W'(RESET_VEC);
            PC_CALL: begin
               push     = 1'b1;
               redirect = 1'b1;
               if (ras_full) ovf_d = 1'b1;
            end
            PC_RET: begin
               redirect = 1'b1;
               if (ras_empty) begin
                  unf_d = 1'b1;
               end else begin
                  pop  = 1'b1;
                  dest = ras_dout;
               end
            end
            default: pc_d = pc_q;
         endcase
      end
      if (redirect) begin
`ifdef PC_ALIGN_TRAP_EN
         if ((dest & INC_MASK) != '0) begin
            pc_d       = PC_W'(TRAP_VEC);
            misalign_d = 1'b1;
         end else begin
            pc_d = dest;
         end
`else
         pc_d = dest & ALIGN_MASK;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= PC_W'(RESET_VEC);
         fetch_valid_q <= 1'b0;
         ovf_q         <= 1'b0;
         unf_q         <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         fetch_valid_q <= 1'b1;
         ovf_q         <= ovf_d;
         unf_q         <= unf_d;
      end
   end

`ifdef PC_ALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (reset) misalign_q <= 1'b0;
      else       misalign_q <= misalign_d;
   end
   assign io.misalign = misalign_q;
`endif

   assign io.pc          = pc_q;
   assign io.pc_seq      = pc_seq;
   assign io.fetch_valid = fetch_valid_q;
   assign io.ras_empty   = ras_empty;
   assign io.ras_full    = ras_full;
   assign io.ras_ovf     = ovf_q;
   assign io.ras_unf     = unf_q;
endmodule

// File: tb/tb_pc_ctrl_ras.sv
// Directed table-driven bench for pc_ctrl_ras (default parameters), plus stall/reset/trap sequences.
module tb_pc_ctrl_ras;
   import pc_pkg::*;

   typedef struct {
      logic        rst;
      logic [2:0]  sel;
      logic [1:0]  tsel;
      logic [31:0] result;
      logic [31:0] rd;
      logic [9:0]  imm;
      logic        stall;
      logic        fr;
      logic [9:0]  epc;
      logic        efv;
      logic        eempty;
      logic        efull;
      logic        eovf;
      logic        eunf;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   pc_ctrl_ras_if #(.PC_W(10), .IMM_W(10)) bus ();

   pc_ctrl_ras dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic void add(input logic rst, input logic [2:0] sel, input logic [1:0] tsel,
                               input logic [31:0] result, input logic [31:0] rd, input logic [9:0] imm,
                               input logic stall, input logic fr, input logic [9:0] epc,
                               input logic efv, input logic eempty, input logic efull,
                               input logic eovf, input logic eunf);
      vec_t v;
      v.rst = rst; v.sel = sel; v.tsel = tsel; v.result = result; v.rd = rd; v.imm = imm;
      v.stall = stall; v.fr = fr; v.epc = epc; v.efv = efv; v.eempty = eempty;
      v.efull = efull; v.eovf = eovf; v.eunf = eunf;
      vecs.push_back(v);
   endfunction

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      reset           = v.rst;
      bus.pc_sel      = v.sel;
      bus.tgt_sel     = v.tsel;
      bus.result      = v.result;
      bus.rd_val      = v.rd;
      bus.imm         = v.imm;
      bus.stall       = v.stall;
      bus.fetch_ready = v.fr;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkVec(input int idx, input vec_t v);
      string tag;
      tag = $sformatf("vec%0d", idx);
      checkOutput({tag, " pc"}, 32'(bus.pc), 32'(v.epc));
      checkOutput({tag, " pc_seq"}, 32'(bus.pc_seq), 32'((v.epc + 10'd2) & 10'h3FF));
      checkOutput({tag, " fetch_valid"}, 32'(bus.fetch_valid), 32'(v.efv));
      checkOutput({tag, " ras_empty"}, 32'(bus.ras_empty), 32'(v.eempty));
      checkOutput({tag, " ras_full"}, 32'(bus.ras_full), 32'(v.efull));
      checkOutput({tag, " ras_ovf"}, 32'(bus.ras_ovf), 32'(v.eovf));
      checkOutput({tag, " ras_unf"}, 32'(bus.ras_unf), 32'(v.eunf));
   endtask

   initial begin
      vec_t h;
      reset = 1'b1;
      bus.pc_sel = PC_HOLD; bus.tgt_sel = TGT_RESULT; bus.result = '0; bus.rd_val = '0;
      bus.imm = '0; bus.stall = 1'b0; bus.fetch_ready = 1'b0;

      //  rst sel      tsel        result    rd       imm     stl fr  epc     fv emp ful ovf unf
      add(1, PC_INC,  TGT_RESULT, 32'h0,    32'h0,  10'h0,   0, 1, 10'h000, 0, 1, 0, 0, 0);
      add(0, PC_INC,  TGT_RESULT, 32'h0,    32'h0,  10'h0,   0, 1, 10'h000, 1, 1, 0, 0, 0);
      add(0, PC_INC,  TGT_RESULT, 32'h0,    32'h0,  10'h0,   0, 1, 10'h002, 1, 1, 0, 0, 0);
      add(0, PC_INC,  TGT_RESULT, 32'h0,    32'h0,  10'h0,   0, 1, 10'h004, 1, 1, 0, 0, 0);
      add(0, PC_INC,  TGT_RESULT, 32'h0,    32'h0,  10'h0,   0, 1, 10'h006, 1, 1, 0, 0, 0);
      add(0, PC_JMP,  TGT_RESULT, 32'h3FE,  32'h0,  10'h0,   0, 1, 10'h3FE, 1, 1, 0, 0, 0);
      add(0, PC_INC,  TGT_RESULT, 32'h0,    32'h0,  10'h0,   0, 1, 10'h000, 1, 1, 0, 0, 0);
      add(0, PC_JMP,  TGT_IMM,    32'h0,    32'h0,  10'h104, 0, 1, 10'h104, 1, 1, 0, 0, 0);
      add(0, PC_JMP,  TGT_RESULT, 32'h010,  32'h0,  10'h0,   0, 1, 10'h010, 1, 1, 0, 0, 0);
      add(0, PC_CALL, TGT_RESULT, 32'h200,  32'h0,  10'h0,   0, 1, 10'h200, 1, 0, 0, 0, 0);
      add(0, PC_RET,  TGT_RESULT, 32'h0,    32'h0,  10'h0,   0, 1, 10'h012, 1, 1, 0, 0, 0);
      add(0, PC_CALL, TGT_RESULT, 32'h100,  32'h0,  10'h0,   0, 1, 10'h100, 1, 0, 0, 0, 0);
      add(0, PC_CALL, TGT_RESULT, 32'h120,  32'h0,  10'h0,   0, 1, 10'h120, 1, 0, 0, 0, 0);
      add(0, PC_CALL, TGT_RESULT, 32'h140,  32'h0,  10'h0,   0, 1, 10'h140, 1, 0, 0, 0, 0);
      add(0, PC_CALL, TGT_RESULT, 32'h160,  32'h0,  10'h0,   0, 1, 10'h160, 1, 0, 1, 0, 0);
      add(0, PC_CALL, TGT_RESULT, 32'h180,  32'h0,  10'h0,   0, 1, 10'h180, 1, 0, 1, 1, 0);
      add(0, PC_RET,  TGT_RESULT, 32'h0,    32'h0,  10'h0,   0, 1, 10'h162, 1, 0, 0, 1, 0);
      add(0, PC_RET,  TGT_RESULT, 32'h0,    32'h0,  10'h0,   0, 1, 10'h142, 1, 0, 0, 1, 0);
      add(0, PC_RET,  TGT_RESULT, 32'h0,    32'h0,  10'h0,   0, 1, 10'h122, 1, 0, 0, 1, 0);
      add(0, PC_RET,  TGT_RESULT, 32'h0,    32'h0,  10'h0,   0, 1, 10'h102, 1, 1, 0, 1, 0);
      add(0, PC_RET,  TGT_RD,     32'h0,    32'h40, 10'h0,   0, 1, 10'h040, 1, 1, 0, 1, 1);
      add(0, PC_JMP,  TGT_RESULT, 32'h300,  32'h0,  10'h0,   1, 1, 10'h040, 1, 1, 0, 1, 1);
      add(0, PC_JMP,  TGT_RESULT, 32'h300,  32'h0,  10'h0,   0, 0, 10'h040, 1, 1, 0, 1, 1);
      add(0, PC_CALL, TGT_RESULT, 32'h200,  32'h0,  10'h0,   0, 1, 10'h200, 1, 0, 0, 1, 1);
      add(0, PC_RET,  TGT_RESULT, 32'h0,    32'h0,  10'h0,   1, 1, 10'h200, 1, 0, 0, 1, 1);
      add(0, PC_RET,  TGT_RESULT, 32'h0,    32'h0,  10'h0,   0, 0, 10'h200, 1, 0, 0, 1, 1);
      add(1, PC_CALL, TGT_RESULT, 32'h300,  32'h0,  10'h0,   0, 1, 10'h000, 0, 1, 0, 0, 0);
      add(0, PC_RET,  TGT_RESULT, 32'h0,    32'h0,  10'h0,   0, 1, 10'h000, 1, 1, 0, 0, 0);
`ifdef PC_ALIGN_TRAP_EN
      add(0, PC_JMP,  TGT_RESULT, 32'h101,  32'h0,  10'h0,   0, 1, 10'h000, 1, 1, 0, 0, 0);
`else
      add(0, PC_JMP,  TGT_RESULT, 32'h101,  32'h0,  10'h0,   0, 1, 10'h100, 1, 1, 0, 0, 0);
`endif
      add(0, PC_JMP,  TGT_IMM,    32'h0,    32'h0,  10'h104, 0, 1, 10'h104, 1, 1, 0, 0, 0);
      add(0, PC_INC,  TGT_RESULT, 32'h0,    32'h0,  10'h0,   0, 1, 10'h106, 1, 1, 0, 0, 0);
      add(0, PC_RST,  TGT_RESULT, 32'h0,    32'h0,  10'h0,   0, 1, 10'h000, 1, 1, 0, 0, 0);
      add(0, PC_INC,  TGT_RESULT, 32'h0,    32'h0,  10'h0,   0, 1, 10'h002, 1, 1, 0, 0, 0);
      add(0, PC_HOLD, TGT_RESULT, 32'h200,  32'h0,  10'h0,   0, 1, 10'h002, 1, 1, 0, 0, 0);
      add(0, 3'b110,  TGT_RESULT, 32'h200,  32'h0,  10'h0,   0, 1, 10'h002, 1, 1, 0, 0, 0);
      add(0, 3'b111,  TGT_RESULT, 32'h200,  32'h0,  10'h0,   0, 1, 10'h002, 1, 1, 0, 0, 0);
      add(0, PC_JMP,  TGT_ZERO,   32'h3FE,  32'h0,  10'h0,   0, 1, 10'h000, 1, 1, 0, 0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkVec(i, vecs[i]);
      end

      // Held stall across several cycles, then a single advance on release
      h = vecs[vecs.size() - 1];
      h.rst = 0; h.sel = PC_INC; h.tsel = TGT_RESULT; h.stall = 1; h.fr = 1;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(h);
         checkOutput($sformatf("stall hold %0d pc", k), 32'(bus.pc), 32'h000);
      end
      h.stall = 0;
      applyStimulus(h);
      checkOutput("stall release pc", 32'(bus.pc), 32'h002);

      // Reset asserted while stalled overrides everything
      h.rst = 1; h.stall = 1;
      applyStimulus(h);
      checkOutput("reset in stall pc", 32'(bus.pc), 32'h000);
      checkOutput("reset in stall fetch_valid", 32'(bus.fetch_valid), 32'h0);
      h.rst = 0; h.stall = 0; h.sel = PC_HOLD;
      applyStimulus(h);
      checkOutput("post reset fetch_valid", 32'(bus.fetch_valid), 32'h1);

`ifdef PC_ALIGN_TRAP_EN
      h.sel = PC_JMP; h.result = 32'h101;
      applyStimulus(h);
      checkOutput("trap jmp pc", 32'(bus.pc), 32'h000);
      checkOutput("trap jmp misalign", 32'(bus.misalign), 32'h1);
      h.sel = PC_HOLD;
      applyStimulus(h);
      checkOutput("trap pulse end misalign", 32'(bus.misalign), 32'h0);
      h.sel = PC_CALL; h.result = 32'h103;
      applyStimulus(h);
      checkOutput("trap call pc", 32'(bus.pc), 32'h000);
      checkOutput("trap call misalign", 32'(bus.misalign), 32'h1);
      checkOutput("trap call pushed", 32'(bus.ras_empty), 32'h0);
      h.sel = PC_RET;
      applyStimulus(h);
      checkOutput("ret after trap pc", 32'(bus.pc), 32'h002);
      checkOutput("ret after trap misalign", 32'(bus.misalign), 32'h0);
      checkOutput("ret after trap empty", 32'(bus.ras_empty), 32'h1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
